// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
// Multiply: {hi,lo} is the product/multiplier pair. Divide: hi = partial remainder, lo = dividend/quotient.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] m,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi_c,
    output logic [XLEN-1:0] lo_c
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        // Partial remainder stays below the divisor, so the 33-bit borrow is the restore flag.
        diff = {hi, lo[XLEN-1]} - {1'b0, m};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_c = diff[XLEN-1:0];
                lo_c = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_c = {hi[XLEN-2:0], lo[XLEN-1]};
                lo_c = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_c = sum[XLEN:1];
            lo_c = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 iterations per op, zero-iteration special cases,
// start/done handshake with a registered result for the writeback mux.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        f3, f3_n;
    logic              sa, sa_n, sb, sb_n;
    logic [XLEN-1:0]   m, m_n, hi, hi_n, lo, lo_n, result_n;
    logic [XLEN-1:0]   step_hi, step_lo, fix_val;

    logic              sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Operand decode at start: signedness, magnitudes and zero-iteration cases
    always_comb begin
        sgn_a    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        sgn_b    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = sgn_a & rs1_val[XLEN-1];
        b_neg    = sgn_b & rs2_val[XLEN-1];
        mag_a    = a_neg ? (~rs1_val + XLEN'(1)) : rs1_val;
        mag_b    = b_neg ? (~rs2_val + XLEN'(1)) : rs2_val;
        div_zero = funct3[2] && (rs2_val == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1_val == MIN_NEG) && (rs2_val == '1);
    end

    muldiv_step u_step (
        .is_div (f3[2]),
        .m      (m),
        .hi     (hi),
        .lo     (lo),
        .hi_c   (step_hi),
        .lo_c   (step_lo)
    );

    // Sign fix and result select on the accumulators produced by the final iteration
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = (sa ^ sb) ? (~prod + (2*XLEN)'(1)) : prod;
        quo_fix  = (sa ^ sb) ? (~step_lo + XLEN'(1)) : step_lo;
        rem_fix  = sa ? (~step_hi + XLEN'(1)) : step_hi;
        case (f3)
            F3_MUL:                        fix_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_val = quo_fix;
            default:                       fix_val = rem_fix;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        f3_n     = f3;
        sa_n     = sa;
        sb_n     = sb;
        m_n      = m;
        hi_n     = hi;
        lo_n     = lo;
        result_n = result;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    f3_n  = funct3;
                    sa_n  = a_neg;
                    sb_n  = b_neg;
                    cnt_n = '0;
                    if (div_zero) begin
                        state_n  = ST_DONE;
                        result_n = (funct3 == F3_DIV || funct3 == F3_DIVU) ? '1 : rs1_val;
                    end else if (div_ovf) begin
                        state_n  = ST_DONE;
                        result_n = (funct3 == F3_DIV) ? MIN_NEG : '0;
                    end else begin
                        state_n = ST_CALC;
                        hi_n    = '0;
                        m_n     = funct3[2] ? mag_b : mag_a;
                        lo_n    = funct3[2] ? mag_a : mag_b;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CALC: begin
                hi_n  = step_hi;
                lo_n  = step_lo;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(XLEN-1)) begin
                    state_n  = ST_DONE;
                    result_n = fix_val;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            f3     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            f3     <= f3_n;
            sa     <= sa_n;
            sb     <= sb_n;
            m      <= m_n;
            hi     <= hi_n;
            lo     <= lo_n;
            result <= result_n;
            busy   <= (state_n == ST_CALC);
            done   <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, randomised model run and control corner cases.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] xa, xb, p;
        int          ia, ib;
        logic        ovf;
        xa  = {{32{((f == F3_MULH) || (f == F3_MULHSU)) & a[31]}}, a};
        xb  = {{32{(f == F3_MULH) & b[31]}}, b};
        p   = xa * xb;
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F3_MUL:  return p[31:0];
            F3_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            F3_REMU: return (b == 0) ? a : a % b;
            default: return p[63:32];
        endcase
    endfunction

    function automatic bit is_spec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && b == 0) ||
               ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called at a negedge; returns 1 ns after the accepting edge with operands scrambled
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        funct3  = 3'($urandom_range(0, 7));
        rs1_val = $urandom;
        rs2_val = $urandom;
    endtask

    // Samples on negedges until done; optional one-cycle start pulse at sample 'glitch'
    task automatic wait_done(input int glitch, output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (glitch > 0 && n == glitch + 1) start = 1'b0;
            if (done === 1'b1) begin
                cyc = n;
                break;
            end
            if (busy === 1'b1) nbusy++;
            if (glitch > 0 && n == glitch) begin
                start   = 1'b1;
                funct3  = F3_DIV;
                rs1_val = 32'd5;
                rs2_val = 32'd0;
            end
        end
    endtask

    task automatic finish_op(input string name, input int exp_cyc, input int glitch);
        int          cyc, nb;
        logic [31:0] e;
        wait_done(glitch, cyc, nb);
        chk({name, " latency"}, 32'(cyc), 32'(exp_cyc));
        chk({name, " busy cycles"}, 32'(nb), 32'(exp_cyc - 1));
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, " result"}, result, e);
        end
    endtask

    initial begin
        int          npulse;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs.push_back('{"mul 7*-3",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{"mulhu -1*-1",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"mulh -1*-1",    F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mulhsu -1*-1",  F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"mul -1*-1",     F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{"mulh min*min",  F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0});
        vecs.push_back('{"div -7/2",      F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"rem -7/2",      F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"div 7/-2",      F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"rem 7/-2",      F3_REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{"divu 100/7",    F3_DIVU,   32'd100,        32'd7,         32'h0000_000E, 1'b0});
        vecs.push_back('{"remu 100/7",    F3_REMU,   32'd100,        32'd7,         32'h0000_0002, 1'b0});
        vecs.push_back('{"div 5/0",       F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"remu 5/0",      F3_REMU,   32'd5,          32'd0,         32'h0000_0005, 1'b1});
        vecs.push_back('{"rem -5/0",      F3_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{"div ovf",       F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"rem ovf",       F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{"div min/1",     F3_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
        vecs.push_back('{"remu max/16",   F3_REMU,   32'hFFFF_FFFF,  32'd16,        32'h0000_000F, 1'b0});

        rst     = 1'b1;
        start   = 1'b0;
        funct3  = '0;
        rs1_val = '0;
        rs2_val = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each op is issued in the DONE cycle of the previous one
        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].exp);
            issue(vecs[i].f3, vecs[i].a, vecs[i].b);
            finish_op(vecs[i].name, vecs[i].spec ? 1 : 33, 0);
        end

        @(negedge clk);
        chk("done single pulse", 32'(done), 32'd0);
        chk("result hold", result, 32'h0000_000F);

        sb_q.push_back(32'hFFFF_FFEB);
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        finish_op("start while busy ignored", 33, 5);

        for (int k = 0; k < 16; k++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            sb_q.push_back(model(rf, ra, rb));
            issue(rf, ra, rb);
            finish_op($sformatf("random %0d f3=%0d", k, rf), is_spec(rf, ra, rb) ? 1 : 33, 0);
        end

        // Reset in the middle of CALC aborts the op
        @(negedge clk);
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'd0);
        rst    = 1'b0;
        npulse = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) npulse++;
        end
        chk("no done after abort", 32'(npulse), 32'd0);
        chk("idle after abort", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It takes the two source operands read from register ports RD1/RD2 plus the M-extension funct3. It computes the result over multiple cycles with a start/done handshake. The registered result goes to the writeback mux that drives register-file write data.

## Interface
Parameters:
- XLEN, 32: operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  input  XLEN  operand A (from RD1).
- rs2_val  input  XLEN  operand B (from RD2).
- busy  output  1  operation in progress; high in CALC only.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  registered result; holds until the next completion or reset.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE/DONE + start=1 → latch funct3, operand magnitudes, and sign flags (sa, sb).
    - Special case → DONE.
    - Otherwise → CALC with cnt=0.
  - IDLE/DONE + start=0 → IDLE.
  - CALC: one iteration per cycle. At cnt=31, go to DONE and load result; cnt wraps to 0.
  - DONE: done=1 for exactly one cycle. A start here is accepted, giving back-to-back operation.
- start while busy=1 is ignored, with no effect on the operation in flight.
- Operand signedness:
  - Signed: MULH (A, B), MULHSU (A only), DIV/REM (A, B).
  - All other cases are unsigned. Magnitude = two's-complement negate if signed and negative.
- Multiply: 64-bit shift-add on magnitudes, 32 iterations.
  - Negate the 64-bit product if sa^sb.
  - MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits.
- Divide: restoring division on magnitudes, 32 iterations, with a 33-bit partial-remainder subtract.
  - Quotient sign = sa^sb; remainder sign = sa.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, detected at start and taking zero iterations:
  - B=0, div op: quotient 0xFFFFFFFF, remainder = rs1_val (both signed and unsigned).
  - DIV/REM with A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Sign fix and result selection are combinational on the final accumulators and captured into result on entry to DONE.
- All arithmetic is modulo 2^XLEN / 2^(2·XLEN); no exceptions are raised.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, cnt=0, internal accumulators=0.
- Reset mid-CALC aborts the operation; outputs take their reset values the next cycle.
- rst has priority over start in the same cycle.
- Normal op: start sampled at edge T.
  - busy=1 from T+1 through T+32.
  - done=1 and result valid at T+33.
  - Latency 33 cycles; throughput one op per 33 cycles with back-to-back starts.
- Special case: start at T, done=1 at T+1, busy never asserted.
- Operands are latched at T. rs1_val/rs2_val/funct3 may change freely afterwards.
- result changes only on entry to DONE or on reset.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 localparams (F3_MUL … F3_REMU).
  - State enum (ST_IDLE, ST_CALC, ST_DONE).
  - XLEN and the count width constant ($clog2(XLEN)).
- One sub-module is natural: `muldiv_step`, a combinational single-iteration datapath for both shift-add multiply and restoring-divide steps. It is instantiated once by `muldiv_unit`.
- FSM, counter, latches, and sign fix live in the top.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start at T → busy T+1..T+32, done at T+33, result 0xFFFFFFEB.
- A=B=0xFFFFFFFF → MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF; MUL 0x00000001.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF, done at T+1, busy stays 0.
  - REMU 5/0 → 0x00000005.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; both done at T+1.
- Control:
  - Start during busy with other operands → ignored, original result delivered.
  - Start in DONE cycle → second result at +33.
  - rst at T+10 → busy=0, done=0, result=0 next cycle; no done pulse afterwards.
